melody_seq: RTL
===============

# melody_seq

Programmable melody sequencer: plays a stored list of (pitch, duration) notes and drives the pitch divider value into the sine-rate `clkgen`. It generalises the fixed 20-note player: runtime-writable note memory, parametrised depth and widths, rests, start/stop control, and one-shot or loop mode. It sits between control logic and the `clkgen`/`sine`/`dac` chain, timed by the fs strobe.

## Interface
- `DEPTH`, 32: note memory entries (power of two, ≥2); `AW = $clog2(DEPTH)`
- `PITCH_W`, 5: pitch (clkgen maxval) width
- `DUR_W`, 13: duration width, in ticks
- `GAP_TICKS`, 1: silent ticks between notes (used only with `MELODY_GAP_EN`)
- `clk` in 1: clock; the block uses this single clock
- `reset` in 1: synchronous, active-high reset
- `tick` in 1: one-cycle time-base strobe (fs_clk)
- `wr_en` in 1, `wr_addr` in AW, `wr_pitch` in PITCH_W, `wr_dur` in DUR_W: note memory write port
- `len` in AW+1: song length in notes, 0..DEPTH
- `start` in 1, `stop` in 1: one-cycle commands
- `loop` in 1: 1 = repeat song, 0 = one-shot
- `pitch_o` out PITCH_W: divider value for clkgen; 0 = silent
- `note_valid` out 1: tone sounding (playing and pitch ≠ 0)
- `note_start` out 1: one-cycle pulse when a note is entered
- `note_idx` out AW: index of the current note
- `busy` out 1: sequencer not IDLE
- `done` out 1: one-cycle pulse when a one-shot song ends or stop is taken

## Operation
- States: IDLE, PLAY, plus GAP when `MELODY_GAP_EN` is defined.
- Entering a note latches `pitch` and `dur` from memory[idx] into registers. Writes during play affect only notes entered later.
- Pitch value 0 is a rest: `pitch_o`=0 and `note_valid`=0 for the full duration.
- A note lasts max(dur,1) ticks. `ctr` increments on each `tick`. On the tick where ctr == max(dur,1)−1, the note ends and `ctr` clears.
- At note end with idx < len−1: go to idx+1 and pulse `note_start`.
- At note end with idx == len−1: `loop` is sampled on that cycle.
  - `loop`=1: go to idx 0 and pulse `note_start`.
  - `loop`=0: pulse `done`, enter IDLE, set `pitch_o` to 0.
- `start` in IDLE with len ≥ 1: enter PLAY at idx 0 with ctr 0.
- `start` in IDLE with len == 0: ignored, no `done`.
- `start` while busy: ignored.
- `stop` while busy: enter IDLE, clear `pitch_o`, pulse `done`.
- `stop` has priority over `start` and over tick-driven advance in the same cycle.
- `len` is sampled at every note-end comparison. If `len` is reduced below idx+1 mid-song, the current note is treated as the last note.
- `len` > DEPTH saturates to DEPTH.
- `ctr` width is DUR_W. Comparisons are unsigned; no overflow is possible.

## Timing
- All outputs are registered.
- Reset values: `pitch_o`=0, `note_valid`=0, `note_start`=0, `note_idx`=0, `busy`=0, `done`=0, state IDLE, ctr=0.
- Reset mid-song aborts immediately, with no `done` pulse. Memory contents are not cleared by reset.
- Latency:
  - `start` in cycle n gives `busy`, `note_start` and `pitch_o` valid in cycle n+1.
  - Note-end `tick` in cycle m gives new `pitch_o`/`note_idx` and `note_start` in cycle m+1.
  - `done` in cycle m+1 coincides with `busy` falling.
- A memory write in cycle w is visible to a note entered in cycle w+1 or later.
- `tick` arriving in the same cycle as `start` is not counted.

## Configuration
- `MELODY_GAP_EN` defined:
  - Each note end (except the final note of a one-shot) enters GAP for `GAP_TICKS` ticks.
  - During GAP: `pitch_o`=0, `note_valid`=0, `busy`=1, `note_idx` holds the finished note.
  - GAP exits to the next note with `note_start`.
  - The `loop` decision is taken at the end of the last note, before GAP.
- Not defined: notes are contiguous, and the GAP state and `GAP_TICKS` logic are not compiled in.

## Structure
- `melody_pkg` holds:
  - State enum (IDLE, PLAY, GAP).
  - Note constants `REST`=0, D=27, E=24, Fis=21, G=20, A=18, B=16, C=15, Dhigh=13.
  - Note struct `{pitch, dur}`.
- Sub-module `melody_ram`: DEPTH × (PITCH_W+DUR_W), one synchronous write port, asynchronous read.

## Test plan
- Write 3 notes {G,4},{REST,2},{A,1}, len=3, loop=0, start.
  - `pitch_o` = 20 for 4 ticks, then 0 for 2 ticks, then 18 for 1 tick.
  - Three `note_start` pulses; `done` one cycle after the 7th tick.
- Same song with loop=1: after the 7th tick, idx returns to 0, `pitch_o`=20, `note_start` fires, and there is no `done`. Then drop loop to 0: the song ends after the next pass.
- Note with dur=0: lasts exactly 1 tick. len=0 with start: `busy` stays 0 and no `done`.
- stop and tick asserted in the same cycle mid-note: IDLE, `pitch_o`=0, `done`=1 next cycle, and idx does not advance. reset mid-note: all outputs 0 and no `done`.
- Overwrite entry 1 while note 0 plays: the new value is heard at note 1. Overwrite entry 0 during note 0: the current pitch is unchanged.
- With `MELODY_GAP_EN`, GAP_TICKS=2, song {G,3},{A,3}, one-shot: 20 for 3 ticks, 0 for 2 ticks, 18 for 3 ticks, then `done` with no trailing gap.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared types and note constants for the melody sequencer (melody_seq, melody_ram).
// The GAP state is only reached when melody_seq is built with MELODY_GAP_EN.
package melody_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int PITCH_W_DEF = 5;
  localparam int DUR_W_DEF   = 13;

  // clkgen divider values; a smaller value gives a higher tone
  localparam logic [PITCH_W_DEF-1:0] REST  = 5'd0;
  localparam logic [PITCH_W_DEF-1:0] D     = 5'd27;
  localparam logic [PITCH_W_DEF-1:0] E     = 5'd24;
  localparam logic [PITCH_W_DEF-1:0] Fis   = 5'd21;
  localparam logic [PITCH_W_DEF-1:0] G     = 5'd20;
  localparam logic [PITCH_W_DEF-1:0] A     = 5'd18;
  localparam logic [PITCH_W_DEF-1:0] B     = 5'd16;
  localparam logic [PITCH_W_DEF-1:0] C     = 5'd15;
  localparam logic [PITCH_W_DEF-1:0] Dhigh = 5'd13;

  typedef struct packed {
    logic [PITCH_W_DEF-1:0] pitch;
    logic [DUR_W_DEF-1:0]   dur;
  } note_t;

endpackage

// File: rtl/melody_ram.sv
// Note memory: one synchronous write port, one asynchronous read port.
module melody_ram
  import melody_pkg::*;
#(
  parameter int  DEPTH = 32,
  parameter int  WIDTH = 18,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/melody_seq.sv
// Programmable melody sequencer driving the clkgen divider value from a note list.
// Define MELODY_GAP_EN to insert GAP_TICKS silent ticks between consecutive notes.
module melody_seq
  import melody_pkg::*;
#(
  parameter int  DEPTH     = 32,
  parameter int  PITCH_W   = 5,
  parameter int  DUR_W     = 13,
  parameter int  GAP_TICKS = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PITCH_W-1:0] wr_pitch,
  input  logic [DUR_W-1:0]   wr_dur,
  input  logic [AW:0]        len,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  output logic [PITCH_W-1:0] pitch_o,
  output logic               note_valid,
  output logic               note_start,
  output logic [AW-1:0]      note_idx,
  output logic               busy,
  output logic               done
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_TICKS < 1) begin : g_param_check
    $error("melody_seq: DEPTH must be a power of two >= 2 and GAP_TICKS >= 1");
  end

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t                     state, state_n;
  logic [DUR_W-1:0]           ctr, ctr_n, dur_r, dur_n, dur_last;
  logic [AW-1:0]              idx_n, idx_next, rd_addr;
  logic [PITCH_W-1:0]         pitch_n, rd_pitch;
  logic [DUR_W-1:0]           rd_dur;
  logic [PITCH_W+DUR_W-1:0]   rd_data;
  logic [AW:0]                len_eff;
  logic                       valid_n, start_n, busy_n, done_n;
  logic                       enter, last, note_end;
`ifdef MELODY_GAP_EN
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_TICKS - 1);
  logic                       wrap_r, wrap_n;
`endif

  melody_ram #(.DEPTH(DEPTH), .WIDTH(PITCH_W + DUR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({wr_pitch, wr_dur}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_pitch = rd_data[PITCH_W+DUR_W-1:DUR_W];
  assign rd_dur   = rd_data[DUR_W-1:0];

  // A stored duration of 0 plays like 1; len above DEPTH plays the whole memory
  assign len_eff  = (len > LEN_MAX) ? LEN_MAX : len;
  assign dur_last = (dur_r == '0) ? '0 : dur_r - DUR_W'(1);
  assign note_end = tick && (ctr == dur_last);
  assign last     = ({1'b0, note_idx} + (AW+1)'(1)) >= len_eff;
  assign idx_next = note_idx + AW'(1);

  always_comb begin
    state_n = state;
    ctr_n   = ctr;
    idx_n   = note_idx;
    pitch_n = pitch_o;
    dur_n   = dur_r;
    valid_n = note_valid;
    busy_n  = busy;
    start_n = 1'b0;
    done_n  = 1'b0;
    enter   = 1'b0;
    rd_addr = '0;
`ifdef MELODY_GAP_EN
    wrap_n  = wrap_r;
`endif
    if (state != IDLE && stop) begin
      state_n = IDLE;
      ctr_n   = '0;
      pitch_n = '0;
      valid_n = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b1;
    end else begin
      case (state)
        IDLE: enter = start && !stop && (len_eff != '0);
        PLAY: begin
          if (tick) begin
            if (note_end) begin
              ctr_n   = '0;
              rd_addr = last ? '0 : idx_next;
              if (last && !loop) begin
                state_n = IDLE;
                pitch_n = '0;
                valid_n = 1'b0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
              end else begin
`ifdef MELODY_GAP_EN
                // loop decision is already folded into wrap_n before the gap
                state_n = GAP;
                pitch_n = '0;
                valid_n = 1'b0;
                wrap_n  = last;
`else
                enter   = 1'b1;
`endif
              end
            end else begin
              ctr_n = ctr + DUR_W'(1);
            end
          end
        end
`ifdef MELODY_GAP_EN
        GAP: begin
          if (tick) begin
            if (ctr == GAP_LAST) begin
              rd_addr = wrap_r ? '0 : idx_next;
              enter   = 1'b1;
            end else begin
              ctr_n = ctr + DUR_W'(1);
            end
          end
        end
`endif
        default: state_n = IDLE;
      endcase
    end
    // Note entry: latch pitch/duration of rd_addr as it stands this cycle
    if (enter) begin
      state_n = PLAY;
      ctr_n   = '0;
      idx_n   = rd_addr;
      pitch_n = rd_pitch;
      dur_n   = rd_dur;
      valid_n = (rd_pitch != '0);
      busy_n  = 1'b1;
      start_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ctr        <= '0;
      note_idx   <= '0;
      pitch_o    <= '0;
      note_valid <= 1'b0;
      note_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef MELODY_GAP_EN
      wrap_r     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      ctr        <= ctr_n;
      note_idx   <= idx_n;
      pitch_o    <= pitch_n;
      note_valid <= valid_n;
      note_start <= start_n;
      busy       <= busy_n;
      done       <= done_n;
`ifdef MELODY_GAP_EN
      wrap_r     <= wrap_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    dur_r <= dur_n;
  end

endmodule
